// File: rtl/adpll_pi_filter_gs.sv
// adpll_pi_filter_gs -- gear-shifted PI loop filter with lock-detect FSM, anti-windup and hold
// rev 1.0
`default_nettype none

module adpll_pi_filter_gs #(
  parameter int ERROR_WIDTH   = 8,
  parameter int DCO_CC_WIDTH  = 9,
  parameter int KP_WIDTH      = 4,
  parameter int KP_FRAC_WIDTH = 1,
  parameter int KI_WIDTH      = 6,
  parameter int KI_FRAC_WIDTH = 4,
  parameter int INT_GUARD     = 4,
  parameter int LOCK_THRESH   = 2,
  parameter int LOCK_COUNT    = 16,
  parameter int UNLOCK_THRESH = 8,
  parameter int UNLOCK_COUNT  = 4
) (
  input  logic                           gen_clk_i,
  input  logic                           reset_i,
  input  logic                           error_valid_i,
  input  logic signed [ERROR_WIDTH-1:0]  error_i,
  input  logic        [KP_WIDTH-1:0]     kp_acq_i,
  input  logic        [KI_WIDTH-1:0]     ki_acq_i,
  input  logic        [KP_WIDTH-1:0]     kp_trk_i,
  input  logic        [KI_WIDTH-1:0]     ki_trk_i,
  input  logic                           freeze_i,
  output logic signed [DCO_CC_WIDTH-1:0] dco_cc_o,
  output logic                           dco_cc_valid_o,
  output logic                           locked_o,
  output logic        [1:0]              state_o
);

  localparam int F   = KI_FRAC_WIDTH;
  localparam int IW  = ERROR_WIDTH + KI_WIDTH + INT_GUARD;
  localparam int SW  = IW + 2;
  localparam int AW  = ERROR_WIDTH + 1;
  localparam int LCW = $clog2(LOCK_COUNT + 1);
  localparam int UCW = $clog2(UNLOCK_COUNT + 1);

  localparam logic signed [SW-1:0] I_MAX = SW'((2**(DCO_CC_WIDTH-1)) * (2**F) - 1);
  localparam logic signed [SW-1:0] I_MIN = SW'(-((2**(DCO_CC_WIDTH-1)) * (2**F)));
  localparam logic signed [SW-1:0] O_MAX = SW'(2**(DCO_CC_WIDTH-1) - 1);
  localparam logic signed [SW-1:0] O_MIN = SW'(-(2**(DCO_CC_WIDTH-1)));
  localparam logic signed [SW-1:0] HALF  = SW'(2**(F-1));
  localparam logic [AW-1:0]  LOCK_TH   = AW'(LOCK_THRESH);
  localparam logic [AW-1:0]  UNLOCK_TH = AW'(UNLOCK_THRESH);
  localparam logic [LCW-1:0] LOCK_N    = LCW'(LOCK_COUNT);
  localparam logic [UCW-1:0] UNLOCK_N  = UCW'(UNLOCK_COUNT);

  typedef enum logic [1:0] {
    ST_ACQ   = 2'd0,
    ST_TRACK = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t                    state_q, state_d, prev_q, prev_d;
  logic signed [IW-1:0]      int_q, int_d;
  logic signed [DCO_CC_WIDTH-1:0] cc_q, cc_d;
  logic                      valid_q, valid_d;
  logic                      locked_q, locked_d;
  logic [LCW-1:0]            lock_cnt_q, lock_cnt_d;
  logic [UCW-1:0]            unl_cnt_q, unl_cnt_d;

  // Datapath: signed error times zero-extended gain, all at SW bits.
  logic [KP_WIDTH-1:0]       kp_sel;
  logic [KI_WIDTH-1:0]       ki_sel;
  logic signed [SW-1:0]      e_ext, kp_ext, ki_ext, p_al, i_sum, i_new, sum, rnd;
  logic signed [DCO_CC_WIDTH-1:0] cc_new;
  logic signed [AW-1:0]      e_abs_in;
  logic        [AW-1:0]      e_abs;

  always_comb begin
    kp_sel   = (state_q == ST_TRACK) ? kp_trk_i : kp_acq_i;
    ki_sel   = (state_q == ST_TRACK) ? ki_trk_i : ki_acq_i;
    e_ext    = SW'(error_i);
    kp_ext   = $signed({{(SW-KP_WIDTH){1'b0}}, kp_sel});
    ki_ext   = $signed({{(SW-KI_WIDTH){1'b0}}, ki_sel});
    p_al     = (e_ext * kp_ext) <<< (F - KP_FRAC_WIDTH);
    i_sum    = SW'(int_q) + e_ext * ki_ext;
    if (i_sum > I_MAX)      i_new = I_MAX;
    else if (i_sum < I_MIN) i_new = I_MIN;
    else                    i_new = i_sum;
    sum      = p_al + i_new;
    rnd      = (sum + HALF) >>> F;
    if (rnd > O_MAX)        cc_new = O_MAX[DCO_CC_WIDTH-1:0];
    else if (rnd < O_MIN)   cc_new = O_MIN[DCO_CC_WIDTH-1:0];
    else                    cc_new = rnd[DCO_CC_WIDTH-1:0];
    // Extra bit so the most negative error has a representable magnitude.
    e_abs_in = AW'(error_i);
    e_abs    = e_abs_in[AW-1] ? AW'(-e_abs_in) : AW'(e_abs_in);
  end

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    int_d      = int_q;
    cc_d       = cc_q;
    valid_d    = 1'b0;
    lock_cnt_d = lock_cnt_q;
    unl_cnt_d  = unl_cnt_q;

    if (freeze_i) begin
      if (state_q != ST_HOLD) begin
        prev_d  = state_q;
        state_d = ST_HOLD;
      end
    end else if (state_q == ST_HOLD) begin
      state_d = prev_q;
    end else if (error_valid_i) begin
      int_d   = i_new[IW-1:0];
      cc_d    = cc_new;
      valid_d = 1'b1;
      if (state_q == ST_ACQ) begin
        if (e_abs <= LOCK_TH) begin
          if (lock_cnt_q + LCW'(1) == LOCK_N) begin
            lock_cnt_d = '0;
            state_d    = ST_TRACK;
          end else begin
            lock_cnt_d = lock_cnt_q + LCW'(1);
          end
        end else begin
          lock_cnt_d = '0;
        end
      end else begin
        if (e_abs > UNLOCK_TH) begin
          if (unl_cnt_q + UCW'(1) == UNLOCK_N) begin
            unl_cnt_d = '0;
            state_d   = ST_ACQ;
          end else begin
            unl_cnt_d = unl_cnt_q + UCW'(1);
          end
        end else begin
          unl_cnt_d = '0;
        end
      end
    end

    // HOLD keeps the lock flag it had on entry.
    locked_d = (state_d == ST_HOLD) ? locked_q : (state_d == ST_TRACK);
  end

  always_ff @(posedge gen_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_ACQ;
      prev_q     <= ST_ACQ;
      int_q      <= '0;
      cc_q       <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      lock_cnt_q <= '0;
      unl_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      int_q      <= int_d;
      cc_q       <= cc_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      lock_cnt_q <= lock_cnt_d;
      unl_cnt_q  <= unl_cnt_d;
    end
  end

  assign dco_cc_o       = cc_q;
  assign dco_cc_valid_o = valid_q;
  assign locked_o       = locked_q;
  assign state_o        = state_q;

endmodule

`default_nettype wire
